// File: rtl/reg_file_sb.sv
// 32 x 32 MIPS register file with a pending-write (load) scoreboard and stall output.
// Optional write-first forwarding and stall suppression when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWrite,
    input  logic [AW-1:0]   Wreg,
    input  logic [DW-1:0]   Wdata,
    input  logic [AW-1:0]   rs,
    input  logic [AW-1:0]   rt,
    input  logic            rs_used,
    input  logic            rt_used,
    output logic [DW-1:0]   Rdata1,
    output logic [DW-1:0]   Rdata2,
    input  logic            mark_busy,
    input  logic [AW-1:0]   mark_reg,
    output logic            stall,
    output logic [NREG-1:0] busy_vec
);

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] wr_onehot;
    logic [NREG-1:0] set_onehot;
    logic [NREG-1:0] stall_busy;
    logic            wr_en;
    logic            set_en;
    logic [DW-1:0]   rd1_raw;
    logic [DW-1:0]   rd2_raw;

    function automatic logic [NREG-1:0] one_hot(input logic [AW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign wr_en  = RegWrite && (Wreg != '0);
    assign set_en = mark_busy && (mark_reg != '0);

    always_comb begin
        wr_onehot  = '0;
        set_onehot = '0;
        if (wr_en)  wr_onehot  = one_hot(Wreg);
        if (set_en) set_onehot = one_hot(mark_reg);
        // Set is applied after clear so a new pending load wins over a retiring write.
        busy_d = (busy_q & ~wr_onehot) | set_onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            if (wr_en) regs_q[Wreg] <= Wdata;
        end
    end

    always_comb begin
        rd1_raw    = (rs == '0) ? '0 : regs_q[rs];
        rd2_raw    = (rt == '0) ? '0 : regs_q[rt];
        stall_busy = busy_q;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (Wreg == rs)) rd1_raw = Wdata;
        if (wr_en && (Wreg == rt)) rd2_raw = Wdata;
        stall_busy = busy_q & ~wr_onehot;
`endif
    end

    // Outputs are forced quiet while reset is held, including any forwarded Wdata.
    assign Rdata1   = rst_n ? rd1_raw : '0;
    assign Rdata2   = rst_n ? rd2_raw : '0;
    assign stall    = rst_n && ((rs_used && stall_busy[rs]) || (rt_used && stall_busy[rt]));
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed plan cases plus random traffic against an array-based model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  Wreg;
    logic [31:0] Wdata;
    logic [4:0]  rs, rt;
    logic        rs_used, rt_used;
    logic [31:0] Rdata1, Rdata2;
    logic        mark_busy;
    logic [4:0]  mark_reg;
    logic        stall;
    logic [31:0] busy_vec;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .Wreg(Wreg), .Wdata(Wdata),
        .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .mark_busy(mark_busy), .mark_reg(mark_reg),
        .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    function automatic logic writing(input logic [4:0] idx);
        return RegWrite && (Wreg != 0) && (Wreg == idx);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (writing(idx)) return Wdata;
`endif
        return m_regs[idx];
    endfunction

    function automatic logic pend(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
        if (writing(idx)) return 1'b0;
`endif
        return (idx != 0) && m_busy[idx];
    endfunction

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] a, input logic [4:0] b, input logic au, input logic bu,
                         input logic mb, input logic [4:0] mr);
        RegWrite = we; Wreg = wr; Wdata = wd; rs = a; rt = b;
        rs_used = au; rt_used = bu; mark_busy = mb; mark_reg = mr;
    endtask

    // Checks the combinational view mid-cycle, then advances the model on the edge.
    task automatic tick();
        @(negedge clk);
        check("rdata1", Rdata1, exp_read(rs));
        check("rdata2", Rdata2, exp_read(rt));
        check("stall", {31'b0, stall}, {31'b0, (rs_used && pend(rs)) || (rt_used && pend(rt))});
        check("busy_vec", busy_vec, m_busy);
        @(posedge clk);
        if (RegWrite && Wreg != 0) begin
            m_regs[Wreg] = Wdata;
            m_busy[Wreg] = 1'b0;
        end
        if (mark_busy && mark_reg != 0) m_busy[mark_reg] = 1'b1;
        #1;
    endtask

    task automatic idle(input logic [4:0] a, input logic [4:0] b);
        drive(0, 0, 0, a, b, 1, 1, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 0, 7, 13, 1, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata1", Rdata1, 32'h0);
        check("reset_rdata2", Rdata2, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_busy", busy_vec, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // $0 protection
        drive(1, 0, 32'hFFFF_FFFF, 0, 0, 1, 1, 1, 0);
        tick();
        idle(0, 0);
        tick();
        check("r0_read", Rdata1, 32'h0);
        check("r0_busy", busy_vec, 32'h0);

        // jal link write, read on both ports
        drive(1, 31, 32'h0040_0008, 0, 0, 0, 0, 0, 0);
        tick();
        idle(31, 31);
        #1;
        check("r31_rs", Rdata1, 32'h0040_0008);
        check("r31_rt", Rdata2, 32'h0040_0008);
        tick();

        // same-cycle read of a register being written
        drive(1, 8, 32'h11, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8, 32'hA5A5_A5A5, 8, 0, 1, 0, 0, 0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("wr_cycle_read", Rdata1, 32'hA5A5_A5A5);
`else
        check("wr_cycle_read", Rdata1, 32'h11);
`endif
        tick();
        idle(8, 0);
        #1;
        check("after_edge_read", Rdata1, 32'hA5A5_A5A5);
        tick();

        // load-use stall
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        drive(0, 0, 0, 0, 9, 0, 1, 0, 0);
        #1;
        check("load_use_stall", {31'b0, stall}, 32'h1);
        tick();
        tick();
        drive(1, 9, 32'hCAFE_0009, 0, 9, 0, 1, 0, 0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("wb_cycle_stall", {31'b0, stall}, 32'h0);
`else
        check("wb_cycle_stall", {31'b0, stall}, 32'h1);
`endif
        tick();
        drive(0, 0, 0, 0, 9, 0, 1, 0, 0);
        #1;
        check("post_wb_stall", {31'b0, stall}, 32'h0);
        check("post_wb_busy9", {31'b0, busy_vec[9]}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        drive(0, 0, 0, 0, 9, 1, 0, 0, 0);
        #1;
        check("unused_rt_stall", {31'b0, stall}, 32'h0);
        tick();

        // collisions
        drive(1, 4, 32'h44, 0, 0, 0, 0, 1, 4);
        tick();
        check("collide_same", {31'b0, busy_vec[4]}, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 6);
        tick();
        drive(1, 4, 32'h4444, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 6, 32'h66, 0, 0, 0, 0, 1, 4);
        tick();
        check("collide_diff4", {31'b0, busy_vec[4]}, 32'h1);
        check("collide_diff6", {31'b0, busy_vec[6]}, 32'h0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
            tick();
        end

        // asynchronous reset mid-run
        drive(1, 5, 32'h1234, 0, 0, 0, 0, 1, 12);
        tick();
        idle(5, 5);
        #1;
        check("pre_reset_r5", Rdata1, 32'h1234);
        rst_n = 1'b0;
        #1;
        check("async_reset_r5", Rdata1, 32'h0);
        check("async_reset_busy", busy_vec, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 32 x 32-bit MIPS general-purpose register file with a pending-write scoreboard.
- Receiving end of the write-back path: it consumes the destination-register select (rt / rd / 31) and the write-back data (ALU result / load data / PC+4 / special value) produced by the write-back selectors.
- Its two read ports feed the ALU-B operand select and the jr next-PC select.
- The scoreboard tracks registers with an outstanding multi-cycle write (loads) and raises a stall when a source operand is still pending.

Parameters:
- NREG, 32, number of architectural registers; must be a power of two; address width is log2(NREG) = 5.
- DW, 32, register data width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- RegWrite  input  1  write enable for this cycle.
- Wreg  input  5  destination register index.
- Wdata  input  32  write-back data.
- rs  input  5  read port 1 index.
- rt  input  5  read port 2 index.
- rs_used  input  1  current instruction consumes rs.
- rt_used  input  1  current instruction consumes rt.
- Rdata1  output  32  contents of register rs.
- Rdata2  output  32  contents of register rt.
- mark_busy  input  1  issue of an instruction whose result arrives later (load).
- mark_reg  input  5  destination index of that pending instruction.
- stall  output  1  a used source operand is pending.
- busy_vec  output  32  scoreboard state, bit i = register i pending.

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - all registers = 0; busy_vec = 0.
  - Rdata1 = Rdata2 = 0; stall = 0 while reset is held.
  - Reset asserted mid-operation discards any in-flight write and all pending marks immediately.
- Register 0:
  - always reads 0.
  - writes to index 0 are ignored.
  - mark_busy with mark_reg = 0 is ignored; busy_vec[0] is always 0.
- Write:
  - on rising clk, if RegWrite=1 and Wreg!=0, then reg[Wreg] <= Wdata.
  - one write per cycle.
- Read:
  - combinational, zero latency.
  - Rdata1 = reg[rs], Rdata2 = reg[rt]; both ports may address the same register.
  - Without the bypass feature (see Optional Feature), a read of a register being written this cycle returns the old value; the new value is visible after the edge.
- Scoreboard (updated on rising clk):
  - set: mark_busy=1 and mark_reg!=0 -> busy[mark_reg] <= 1.
  - clear: RegWrite=1 and Wreg!=0 -> busy[Wreg] <= 0.
  - set and clear on the same index in the same cycle: set wins (newer pending load).
  - set and clear on different indices: both take effect.
  - A write to a non-busy register does not change the scoreboard.
- Stall:
  - stall = (rs_used & busy[rs]) | (rt_used & busy[rt]); combinational.
  - An index of 0 never stalls.
  - stall does not block writes or scoreboard updates. The pipeline holds rs/rt stable while stalled.
- All state is held when RegWrite=0 and mark_busy=0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-first internal forwarding: if RegWrite=1, Wreg!=0 and Wreg==rs, then Rdata1 = Wdata in the same cycle. The rt port is handled the same way.
  - The stall term for a register being written this cycle is suppressed (busy bit treated as 0 for the stall calculation only).
  - Register and scoreboard update rules are unchanged.
- Not defined:
  - Read-before-write; a read in the write cycle returns the old value.
  - stall uses busy_vec exactly as registered.

Test Plan:
- Reset: after reset, read any rs/rt -> Rdata1/Rdata2 = 0, stall=0, busy_vec=0; assert rst_n low mid-run after writing reg5=0x1234 -> reg5 reads 0 immediately, without waiting for a clock edge.
- $0 protection: RegWrite=1, Wreg=0, Wdata=0xFFFFFFFF, then rs=0 -> Rdata1=0; mark_busy=1, mark_reg=0 -> busy_vec stays 0.
- Write/read: write reg31=0x00400008 (jal link) -> next cycle rs=31 gives Rdata1=0x00400008; rt=31 simultaneously gives Rdata2=0x00400008.
- Same-cycle read of a register being written (Wreg=8, Wdata=0xA5A5A5A5, rs=8, old value 0x11):
  - without REGFILE_BYPASS_EN: Rdata1=0x11 in that cycle, 0xA5A5A5A5 after the edge.
  - with REGFILE_BYPASS_EN: Rdata1=0xA5A5A5A5 in that cycle.
- Load-use stall: mark_busy=1, mark_reg=9; next cycle rt=9, rt_used=1 -> stall=1; two cycles later RegWrite=1, Wreg=9 -> busy_vec[9]=0 and stall=0 after the edge (or in the write cycle with bypass); with rt_used=0 and busy[9]=1 -> stall=0.
- Collision: in one cycle mark_busy=1, mark_reg=4 and RegWrite=1, Wreg=4 -> busy_vec[4]=1 after the edge; in one cycle mark_reg=4 and Wreg=6 with busy[6]=1 -> busy_vec[4]=1, busy_vec[6]=0.
